serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Receive-side deserializer for the transmit path's serial data. It captures a framed bit stream (one control-mode bit followed by a WIDTH-bit data word, MSB first) and presents the word and mode bit in parallel with a one-cycle completion strobe. It sits at the receiving end of the link fed by the transmit multiplexer's output. It reconstructs both the selected word and the mode that selected it.

## Interface
Parameters:
- WIDTH, default 32, data word width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- RxDin  input  1  serial data bit, sampled on rising clk when RxEn=1.
- RxEn  input  1  frame-valid qualifier; high for exactly WIDTH+1 consecutive cycles per frame.
- RxDout  output  WIDTH  last completed data word, MSB first on the line.
- RxMode  output  1  control-mode bit of the last completed frame.
- RxDone  output  1  one-cycle pulse: RxDout/RxMode just updated.
- RxErr  output  1  one-cycle pulse: frame aborted (RxEn dropped early).
- RxBusy  output  1  high while a frame is in progress, after the mode bit is taken.

## Operation
- Frame is WIDTH+1 bits. Bit 0 is the mode bit, then data bits WIDTH-1 down to 0, one per cycle, RxEn continuously high.
- States: IDLE, DATA.
- IDLE:
  - RxEn=1: capture RxDin into the mode shadow register, clear the bit counter, go to DATA.
  - RxEn=0: stay in IDLE.
- DATA:
  - RxEn=1: shift RxDin into the LSB of the shift register and increment the counter.
  - RxEn=1 on the WIDTH-th data bit (counter = WIDTH-1): load RxDout with the full shifted word, load RxMode from the shadow, pulse RxDone, return to IDLE.
  - RxEn=0 before the frame completes: abort. Pulse RxErr, return to IDLE, leave RxDout/RxMode unchanged, discard the partial word.
- RxDout/RxMode hold their values until the next completed frame. The shift register and mode shadow are internal and never visible on the outputs.
- Counter width is $clog2(WIDTH). The counter never wraps within a legal frame.
- RxBusy = (state == DATA), registered.
- Reset (asynchronous, any state, mid-frame included): state=IDLE, RxDout=0, RxMode=0, RxDone=0, RxErr=0, RxBusy=0, counter=0, shift register=0. A partial frame in progress is lost with no RxErr.

## Timing
- Call the cycle in which the mode bit is sampled cycle 0. Data bits are sampled in cycles 1..WIDTH.
- After the edge that samples data bit 0 (end of cycle WIDTH), RxDone=1 and the new RxDout/RxMode are valid during cycle WIDTH+1.
- Latency: mode bit to RxDone = WIDTH+1 cycles.
- RxDone and RxErr are exactly one cycle wide and never high together.
- Back-to-back frames: RxEn may stay high across the frame boundary. The bit sampled in the RxDone cycle is the next frame's mode bit. Sustained throughput is one frame per WIDTH+1 cycles with no gap.
- Abort timing: if RxEn=0 in cycle k (1 ≤ k ≤ WIDTH), RxErr=1 in cycle k+1 and RxBusy=0 from cycle k+1. If RxEn rises in that same cycle k+1, it starts a new frame as its mode bit.
- RxBusy rises in cycle 1 and falls in cycle WIDTH+1 for a complete frame.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset, then idle 5 cycles with RxEn=0 → RxDout=0, RxMode=0, RxDone=0, RxErr=0, RxBusy=0 throughout.
- WIDTH=32: frame mode=1, data 0x000000FF → RxDone high in cycle 33 only, RxDout=0x000000FF, RxMode=1, RxBusy high in cycles 1..32.
- Back-to-back frames with no gap: (0, 0x00000011) then (1, 0xA5A5A5A5) → RxDone in cycles 33 and 66. RxDout=0x00000011/RxMode=0, then 0xA5A5A5A5/RxMode=1. RxErr stays 0.
- Abort: after a valid (1, 0x000000FF) frame, start a new frame and drop RxEn at data bit 10 → RxErr pulse one cycle, no RxDone, RxDout still 0x000000FF, RxMode still 1.
- Assert reset asynchronously (between clock edges) at data bit 20 of a frame → all outputs 0 immediately. After release, a full frame (0, 0xDEADBEEF) completes normally with RxDout=0xDEADBEEF.
- WIDTH=8 instance: frame (1, 0x81) → RxDone in cycle 9, RxDout=0x81, RxMode=1.

Source files
------------

// File: rtl/serial_word_rx.sv
// Receive deserializer: mode bit then WIDTH data bits (MSB first) -> parallel word.
// Ports: clk, reset, RxDin, RxEn in; RxDout, RxMode, RxDone, RxErr, RxBusy out.
module serial_word_rx #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RxDin,
  input  logic             RxEn,
  output logic [WIDTH-1:0] RxDout,
  output logic             RxMode,
  output logic             RxDone,
  output logic             RxErr,
  output logic             RxBusy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    DATA
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_mode_sh;
  logic [WIDTH-1:0] r_dout;
  logic             r_mode;
  logic             r_done;
  logic             r_err;
  logic             r_busy;

  logic             w_start;
  logic             w_shift;
  logic             w_last;
  logic             w_abort;
  logic [WIDTH-1:0] w_word;

  assign w_word = {r_shift[WIDTH-2:0], RxDin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (RxEn) begin
          w_start     = 1'b1;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (!RxEn) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_shift = 1'b1;
          if (r_cnt == LAST) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_mode_sh <= 1'b0;
      r_dout    <= '0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= w_last;
      r_err  <= w_abort;
      r_busy <= (w_state_nxt == DATA);
      if (w_start) begin
        r_mode_sh <= RxDin;
        r_cnt     <= '0;
      end
      // Hold the counter on the final bit so it never wraps.
      if (w_shift) begin
        r_shift <= w_word;
        if (!w_last) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_last) begin
        r_dout <= w_word;
        r_mode <= r_mode_sh;
      end
    end
  end

  assign RxDout = r_dout;
  assign RxMode = r_mode;
  assign RxDone = r_done;
  assign RxErr  = r_err;
  assign RxBusy = r_busy;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: WIDTH=32 and WIDTH=8 instances, frame table
// plus abort, async-reset and back-to-back sequences.
module tb_serial_word_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din32 = 1'b0, en32 = 1'b0;
  logic        din8 = 1'b0, en8 = 1'b0;
  logic [31:0] dout32;
  logic [7:0]  dout8;
  logic        mode32, done32, err32, busy32;
  logic        mode8, done8, err8, busy8;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .RxDin(din32), .RxEn(en32),
    .RxDout(dout32), .RxMode(mode32), .RxDone(done32),
    .RxErr(err32), .RxBusy(busy32)
  );

  serial_word_rx #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .RxDin(din8), .RxEn(en8),
    .RxDout(dout8), .RxMode(mode8), .RxDone(done8),
    .RxErr(err8), .RxBusy(busy8)
  );

  int total = 0;
  int bad = 0;

  logic        sel8 = 1'b0;
  logic        pend_done = 1'b0;
  logic        pend_err = 1'b0;
  logic [31:0] hold_d [2] = '{32'h0, 32'h0};
  logic        hold_m [2] = '{1'b0, 1'b0};

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic        gap;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sample outputs mid-cycle, check them, then drive the next bit.
  task automatic step(input logic en, input logic din, input logic eb);
    logic [31:0] o;
    logic d, e, b, m;
    int s;
    @(negedge clk);
    s = sel8 ? 1 : 0;
    if (sel8) begin
      o = {24'h0, dout8}; m = mode8; d = done8; e = err8; b = busy8;
    end else begin
      o = dout32; m = mode32; d = done32; e = err32; b = busy32;
    end
    chk("busy", {31'h0, b}, {31'h0, eb});
    chk("done", {31'h0, d}, {31'h0, pend_done});
    chk("err", {31'h0, e}, {31'h0, pend_err});
    chk("dout", o, hold_d[s]);
    chk("mode", {31'h0, m}, {31'h0, hold_m[s]});
    pend_done = 1'b0;
    pend_err = 1'b0;
    if (sel8) begin
      en8 = en; din8 = din; en32 = 1'b0;
    end else begin
      en32 = en; din32 = din; en8 = 1'b0;
    end
  endtask

  task automatic frame(input logic mode, input logic [31:0] data);
    int w;
    w = sel8 ? 8 : 32;
    step(1'b1, mode, 1'b0);
    for (int i = w - 1; i >= 0; i--) step(1'b1, data[i], 1'b1);
    pend_done = 1'b1;
    if (sel8) begin
      hold_d[1] = {24'h0, data[7:0]}; hold_m[1] = mode;
    end else begin
      hold_d[0] = data; hold_m[0] = mode;
    end
  endtask

  initial begin
    logic [31:0] pat;
    vecs[0] = '{mode: 1'b0, data: 32'h0000_0011, gap: 1'b0};
    vecs[1] = '{mode: 1'b1, data: 32'hA5A5_A5A5, gap: 1'b1};
    vecs[2] = '{mode: 1'b0, data: 32'h8000_0001, gap: 1'b0};
    vecs[3] = '{mode: 1'b1, data: 32'h7FFF_FFFE, gap: 1'b1};
    vecs[4] = '{mode: 1'b1, data: 32'h0000_00FF, gap: 1'b1};

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      frame(vecs[i].mode, vecs[i].data);
      if (vecs[i].gap) step(1'b0, 1'b0, 1'b0);
    end

    // Abort after 10 data bits; restart in the RxErr cycle.
    pat = 32'h5555_5555;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 31; i > 21; i--) step(1'b1, pat[i], 1'b1);
    step(1'b0, 1'b0, 1'b1);
    pend_err = 1'b1;
    frame(1'b0, 32'h0000_003C);
    step(1'b0, 1'b0, 1'b0);

    // Async reset between edges at data bit 20.
    pat = 32'hFFFF_FFFF;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 31; i > 11; i--) step(1'b1, pat[i], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", {31'h0, busy32}, 32'h0);
    chk("rst_done", {31'h0, done32}, 32'h0);
    chk("rst_err", {31'h0, err32}, 32'h0);
    chk("rst_mode", {31'h0, mode32}, 32'h0);
    chk("rst_dout", dout32, 32'h0);
    en32 = 1'b0;
    hold_d[0] = 32'h0; hold_m[0] = 1'b0;
    hold_d[1] = 32'h0; hold_m[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    frame(1'b0, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0);

    // WIDTH=8 instance, one gapped frame then two back-to-back.
    sel8 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    frame(1'b1, 32'h0000_0081);
    step(1'b0, 1'b0, 1'b0);
    frame(1'b0, 32'h0000_007E);
    frame(1'b1, 32'h0000_0001);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
